ahb_slave_mem: RTL and testbench

AHB-Lite responder (slave) backed by a word-addressed internal memory. It is the target end of the bus driven by our AHB master FSM. It decodes NONSEQ/SEQ transfers, inserts a configurable number of wait states, and performs byte/halfword/word writes and reads. Illegal accesses get the two-cycle ERROR response, and a sticky error code is kept for debug.

---
 rtl/ahb_slave_mem_pkg.sv | 47 ++++
 rtl/ahb_byte_strobe.sv | 19 +
 rtl/ahb_slave_mem.sv | 170 +++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB-Lite types for the master/slave pair plus the slave FSM encoding.
package ahb_slave_mem_pkg;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } transfer_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } burst_in;

    typedef enum logic [2:0] {
        NO_ERROR           = 3'b000,
        OVERFLOW_ERROR     = 3'b001,
        ABORT_BY_SLAVE     = 3'b010,
        SLAVE_RESPONSE_ERR = 3'b011
    } error_code_t;

    // SLV_ prefix keeps these apart from the IDLE transfer literal.
    typedef enum logic [1:0] {
        SLV_IDLE = 2'b00,
        SLV_WAIT = 2'b01,
        SLV_ERR1 = 2'b10,
        SLV_ERR2 = 2'b11
    } slv_state_t;

    // Width of the wait-state counter (0..15 wait states).
    localparam int SLV_WS_W = 4;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for an AHB transfer of a given size/offset.
module ahb_byte_strobe (
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strobe
);

    // Map transfer size and low address bits onto the four byte lanes.
    always_comb begin
        strobe = 4'b0000;
        case (size)
            3'b000:  strobe = 4'b0001 << addr_lo;
            3'b001:  strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder with word-addressed internal memory, configurable wait
// states, two-cycle ERROR response and a sticky first-error code.
module ahb_slave_mem
    import ahb_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [2:0]            err_code,
    input  logic                  err_clr
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);

    slv_state_t            state, state_nxt;
    error_code_t           err_class, err_q;
    transfer_t             trans;
    resp_t                 resp;
    logic [SLV_WS_W-1:0]   ws_cnt;
    logic [IDX_W+1:0]      addr_q;
    logic [IDX_W-1:0]      idx;
    logic [2:0]            size_q;
    logic                  write_q;
    logic                  dphase_vld;
    logic                  burst_active;
    logic                  sel, accept, complete;
    logic [3:0]            strobe;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign trans    = transfer_t'(HTRANS);
    assign sel      = HSEL & HREADY;
    assign accept   = sel & HTRANS[1];
    assign complete = dphase_vld & (state == SLV_IDLE);
    assign idx      = addr_q[IDX_W+1:2];
    assign err_code = err_q;
    assign HRESP    = resp;
    // Memory is read combinationally so a write committed on the previous
    // edge is already visible in a back-to-back read data phase.
    assign HRDATA   = (complete && !write_q) ? mem[idx] : rdata_q;

    ahb_byte_strobe u_strobe (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .strobe  (strobe)
    );

    // Classify the transfer presented in the address phase, highest priority first.
    always_comb begin
        err_class = NO_ERROR;
        if (HADDR >= MEM_BYTES)
            err_class = OVERFLOW_ERROR;
        else if ((HSIZE > 3'b010) || (HSIZE == 3'b001 && HADDR[0]) ||
                 (HSIZE == 3'b010 && HADDR[1:0] != 2'b00))
            err_class = SLAVE_RESPONSE_ERR;
        else if (trans == SEQ && !burst_active)
            err_class = ABORT_BY_SLAVE;
    end

    // Next-state and bus response decode.
    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        resp      = OKAY;
        case (state)
            SLV_IDLE, SLV_ERR2: begin
                if (state == SLV_ERR2) begin
                    resp      = ERROR;
                    state_nxt = SLV_IDLE;
                end
                if (accept) begin
                    if (err_class != NO_ERROR)
                        state_nxt = SLV_ERR1;
                    else if (WAIT_STATES > 0)
                        state_nxt = SLV_WAIT;
                    else
                        state_nxt = SLV_IDLE;
                end
            end
            SLV_WAIT: begin
                HREADYOUT = 1'b0;
                if (ws_cnt <= SLV_WS_W'(1))
                    state_nxt = SLV_IDLE;
            end
            SLV_ERR1: begin
                HREADYOUT = 1'b0;
                resp      = ERROR;
                state_nxt = SLV_ERR2;
            end
            default: state_nxt = SLV_IDLE;
        endcase
    end

    // FSM state, wait counter, captured transfer attributes and burst/error tracking.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= SLV_IDLE;
            ws_cnt       <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            dphase_vld   <= 1'b0;
            burst_active <= 1'b0;
            err_q        <= NO_ERROR;
            rdata_q      <= '0;
        end else begin
            state <= state_nxt;

            if (state_nxt == SLV_WAIT && state != SLV_WAIT)
                ws_cnt <= SLV_WS_W'(WAIT_STATES);
            else if (state == SLV_WAIT)
                ws_cnt <= ws_cnt - SLV_WS_W'(1);

            if (accept) begin
                addr_q  <= HADDR[IDX_W+1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end

            if (sel)
                dphase_vld <= accept && (err_class == NO_ERROR);
            else if (complete)
                dphase_vld <= 1'b0;

            if (sel) begin
                case (trans)
                    IDLE:    burst_active <= 1'b0;
                    BUSY:    burst_active <= burst_active;
                    NONSEQ:  burst_active <= (err_class == NO_ERROR) &&
                                             (HBURST != SINGLE);
                    default: if (err_class != NO_ERROR) burst_active <= 1'b0;
                endcase
            end

            if (err_clr)
                err_q <= NO_ERROR;
            else if (accept && err_q == NO_ERROR && err_class != NO_ERROR)
                err_q <= err_class;

            if (complete && !write_q)
                rdata_q <= mem[idx];
        end
    end

    // Commit write lanes on the completing OKAY data-phase edge.
    always_ff @(posedge HCLK) begin
        if (complete && write_q) begin
            for (int b = 0; b < 4; b++)
                if (strobe[b])
                    mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: one zero-wait and one two-wait-state instance.
module tb_ahb_slave_mem;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [1:0] R_OK = 2'b00, R_ERR = 2'b01;
    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011;

    typedef struct {
        int          dut;
        logic        rd;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          low;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  hsel, hwrite, hreadyout, err_clr;
    logic [31:0] haddr [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic [2:0]  hburst [2];
    logic [31:0] hwdata [2];
    logic [1:0]  hresp [2];
    logic [31:0] hrdata [2];
    logic [2:0]  errc [2];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   low_cnt = 0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]),
        .HWDATA(hwdata[0]), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0]), .HRDATA(hrdata[0]), .err_code(errc[0]), .err_clr(err_clr[0])
    );

    ahb_slave_mem #(.WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]),
        .HWDATA(hwdata[1]), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1]), .HRDATA(hrdata[1]), .err_code(errc[1]), .err_clr(err_clr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count HREADYOUT-low cycles of the outstanding data phase and
    // compare the completing cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (!hreadyout[sb[0].dut]) begin
                low_cnt++;
                if (low_cnt > 30) begin
                    check({sb[0].name, "_timeout"}, 32'(low_cnt), 32'(sb[0].low));
                    void'(sb.pop_front());
                    low_cnt = 0;
                end
            end else begin
                check({sb[0].name, "_resp"}, 32'(hresp[sb[0].dut]), 32'(sb[0].resp));
                check({sb[0].name, "_lowcyc"}, 32'(low_cnt), 32'(sb[0].low));
                if (sb[0].rd && sb[0].resp == R_OK)
                    check({sb[0].name, "_rdata"}, hrdata[sb[0].dut], sb[0].rdata);
                void'(sb.pop_front());
                low_cnt = 0;
            end
        end
    end

    // Present one address phase, wait for acceptance, queue the expected
    // response, then drive write data for the data phase.
    task automatic xfer(input int d, input string name, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] bu, input logic [1:0] eresp,
                        input logic [31:0] erd, input int elow);
        logic rdy;
        bit   ok;
        exp_t e;
        hsel[d] = 1'b1; htrans[d] = tr; hwrite[d] = wr;
        hsize[d] = sz; haddr[d] = a; hburst[d] = bu;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            rdy = hreadyout[d];
            @(posedge clk);
            if (rdy) ok = 1;
            else #1;
        end
        if (!ok) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
            return;
        end
        e.dut = d; e.rd = !wr; e.resp = eresp; e.rdata = erd; e.low = elow; e.name = name;
        sb.push_back(e);
        #1;
        if (wr) hwdata[d] = wd;
        htrans[d] = T_IDLE;
    endtask

    task automatic busy_cycle(input int d, input logic [31:0] a);
        htrans[d] = T_BUSY; haddr[d] = a;
        @(posedge clk); #1;
        htrans[d] = T_IDLE;
    endtask

    task automatic idle(input int d);
        htrans[d] = T_IDLE;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_err(input int d);
        err_clr[d] = 1'b1;
        @(posedge clk); #1;
        err_clr[d] = 1'b0;
    endtask

    initial begin
        rst_n = 2'b00; err_clr = 2'b00; hsel = 2'b00; hwrite = 2'b00;
        for (int d = 0; d < 2; d++) begin
            haddr[d] = '0; htrans[d] = T_IDLE; hsize[d] = SZ_W;
            hburst[d] = B_SINGLE; hwdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
            check("rst_hresp",     32'(hresp[d]),     32'(R_OK));
            check("rst_hrdata",    hrdata[d],         32'd0);
            check("rst_err_code",  32'(errc[d]),      32'd0);
        end
        @(negedge clk); rst_n = 2'b11;
        @(posedge clk); #1;

        // Zero-wait write then back-to-back read of the same word.
        xfer(0, "w_dead", T_NSEQ, 1, SZ_W, 32'h10, 32'hDEADBEEF, B_SINGLE, R_OK, 0, 0);
        xfer(0, "r_dead", T_NSEQ, 0, SZ_W, 32'h10, 0, B_SINGLE, R_OK, 32'hDEADBEEF, 0);
        idle(0);

        // Byte and halfword lane merges.
        xfer(0, "w_1122", T_NSEQ, 1, SZ_W, 32'h20, 32'h11223344, B_SINGLE, R_OK, 0, 0);
        xfer(0, "w_byte", T_NSEQ, 1, SZ_B, 32'h21, 32'hAAAAAAAA, B_SINGLE, R_OK, 0, 0);
        xfer(0, "r_byte", T_NSEQ, 0, SZ_W, 32'h20, 0, B_SINGLE, R_OK, 32'h1122AA44, 0);
        xfer(0, "w_half", T_NSEQ, 1, SZ_H, 32'h22, 32'hBEEFBEEF, B_SINGLE, R_OK, 0, 0);
        xfer(0, "r_half", T_NSEQ, 0, SZ_W, 32'h20, 0, B_SINGLE, R_OK, 32'hBEEFAA44, 0);
        // Highest valid word.
        xfer(0, "w_top",  T_NSEQ, 1, SZ_W, 32'h3FC, 32'h0BADF00D, B_SINGLE, R_OK, 0, 0);
        xfer(0, "r_top",  T_NSEQ, 0, SZ_W, 32'h3FC, 0, B_SINGLE, R_OK, 32'h0BADF00D, 0);
        idle(0);

        // Out-of-range write: ERROR, no aliasing into word 0, sticky code.
        xfer(0, "w_w0",   T_NSEQ, 1, SZ_W, 32'h0, 32'hCAFEF00D, B_SINGLE, R_OK, 0, 0);
        idle(0);
        xfer(0, "w_ovf",  T_NSEQ, 1, SZ_W, 32'h400, 32'hFFFFFFFF, B_SINGLE, R_ERR, 0, 1);
        idle(0);
        check("err_ovf", 32'(errc[0]), 32'h1);
        xfer(0, "w_mis",  T_NSEQ, 1, SZ_W, 32'h2, 32'h0, B_SINGLE, R_ERR, 0, 1);
        idle(0);
        check("err_sticky", 32'(errc[0]), 32'h1);
        xfer(0, "r_w0",   T_NSEQ, 0, SZ_W, 32'h0, 0, B_SINGLE, R_OK, 32'hCAFEF00D, 0);
        idle(0);
        clear_err(0);
        check("err_clr", 32'(errc[0]), 32'h0);
        xfer(0, "w_mish", T_NSEQ, 1, SZ_H, 32'h1, 32'h0, B_SINGLE, R_ERR, 0, 1);
        idle(0);
        check("err_size", 32'(errc[0]), 32'h3);
        clear_err(0);

        // SEQ with no burst in progress.
        xfer(0, "r_seq",  T_SEQ, 0, SZ_W, 32'h30, 0, B_SINGLE, R_ERR, 0, 1);
        idle(0);
        check("err_abort", 32'(errc[0]), 32'h2);
        clear_err(0);

        // INCR4 burst with one BUSY cycle.
        xfer(0, "b0", T_NSEQ, 1, SZ_W, 32'h40, 32'h00000001, B_INCR4, R_OK, 0, 0);
        busy_cycle(0, 32'h44);
        xfer(0, "b1", T_SEQ,  1, SZ_W, 32'h44, 32'h00000002, B_INCR4, R_OK, 0, 0);
        xfer(0, "b2", T_SEQ,  1, SZ_W, 32'h48, 32'h00000003, B_INCR4, R_OK, 0, 0);
        xfer(0, "b3", T_SEQ,  1, SZ_W, 32'h4C, 32'h00000004, B_INCR4, R_OK, 0, 0);
        idle(0);
        check("err_burst", 32'(errc[0]), 32'h0);
        for (int i = 0; i < 4; i++)
            xfer(0, "rb", T_NSEQ, 0, SZ_W, 32'h40 + 32'(4*i), 0, B_SINGLE, R_OK, 32'(i + 1), 0);
        idle(0);

        // Two wait states; the read is held until the HREADY=1 edge.
        xfer(1, "ws_w", T_NSEQ, 1, SZ_W, 32'h4, 32'hA5A5A5A5, B_SINGLE, R_OK, 0, 2);
        xfer(1, "ws_r", T_NSEQ, 0, SZ_W, 32'h4, 0, B_SINGLE, R_OK, 32'hA5A5A5A5, 2);
        xfer(1, "ws_w8", T_NSEQ, 1, SZ_W, 32'h8, 32'h12345678, B_SINGLE, R_OK, 0, 2);
        idle(1);

        // Reset asserted mid-wait aborts the write.
        hsel[1] = 1'b1; htrans[1] = T_NSEQ; hwrite[1] = 1'b1; hsize[1] = SZ_W; haddr[1] = 32'h8;
        @(posedge clk); #1;
        hwdata[1] = 32'h55555555; htrans[1] = T_IDLE;
        check("wait_low", 32'(hreadyout[1]), 32'd0);
        #2 rst_n[1] = 1'b0;
        #1;
        check("rst_async_ready", 32'(hreadyout[1]), 32'd1);
        check("rst_async_resp",  32'(hresp[1]),     32'(R_OK));
        @(posedge clk);
        @(negedge clk); rst_n[1] = 1'b1;
        @(posedge clk); #1;
        xfer(1, "r_after_rst", T_NSEQ, 0, SZ_W, 32'h8, 0, B_SINGLE, R_OK, 32'h12345678, 2);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
